look_up_req_arb: RTL and testbench

//  Round-robin arbiter and sequencer that shares one lookup pipeline among PORT_NUM ingress key requesters.
//  - Sits between the per-port key extractors and the lookup manager (DMAC/SMAC/clash tables).
//  - Grants one port per transaction and issues its key set to the lookup manager as a 1-cycle valid.
//  - Waits for the tx-port result and returns it, tagged one-hot, to the requesting port.

---
 rtl/look_up_req_arb_pkg.sv | 14 +
 rtl/look_up_req_arb_rr_arbiter.sv | 31 +++
 rtl/look_up_req_arb.sv | 156 +++++++++++++++
 tb/tb_look_up_req_arb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/look_up_req_arb_pkg.sv
// Shared types and widths for the lookup request arbiter.
package look_up_pkg;

    localparam int VLAN_W = 12;
    localparam int MAC_W  = 48;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/look_up_req_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr+1, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int  cand;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/look_up_req_arb.sv
// Shares one lookup pipeline among PORT_NUM requesters: IDLE -> ISSUE -> WAIT -> RESP.
// Optional WAIT watchdog enabled by LOOK_UP_ARB_TIMEOUT_EN.
import look_up_pkg::*;

module look_up_req_arb #(
    parameter int PORT_NUM        = 4,
    parameter int HASH_DATA_WIDTH = 12,
    parameter int TIMEOUT_CYC     = 64
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [PORT_NUM-1:0]               i_req_vld,
    input  logic [PORT_NUM*VLAN_W-1:0]        i_req_vlan_id,
    input  logic [PORT_NUM*MAC_W-1:0]         i_req_dmac,
    input  logic [PORT_NUM*HASH_DATA_WIDTH-1:0] i_req_dmac_hash,
    input  logic [PORT_NUM*MAC_W-1:0]         i_req_smac,
    input  logic [PORT_NUM*HASH_DATA_WIDTH-1:0] i_req_smac_hash,
    output logic [PORT_NUM-1:0]               o_req_ack,
    output logic [VLAN_W-1:0]                 o_vlan_id,
    output logic [PORT_NUM-1:0]               o_dmac_port,
    output logic [HASH_DATA_WIDTH-1:0]        o_dmac_hash_key,
    output logic [MAC_W-1:0]                  o_dmac,
    output logic                              o_dmac_vld,
    output logic [HASH_DATA_WIDTH-1:0]        o_smac_hash_key,
    output logic [MAC_W-1:0]                  o_smac,
    output logic                              o_smac_vld,
    input  logic [PORT_NUM:0]                 i_tx_port,
    input  logic                              i_tx_port_vld,
    output logic [PORT_NUM:0]                 o_rslt_port,
    output logic [PORT_NUM-1:0]               o_rslt_vld,
    output logic                              o_busy,
    output logic                              o_timeout
);

    localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    // Packed views share the flat bus layout: port p sits at element p.
    logic [PORT_NUM-1:0][VLAN_W-1:0]          vlan_a;
    logic [PORT_NUM-1:0][MAC_W-1:0]           dmac_a;
    logic [PORT_NUM-1:0][MAC_W-1:0]           smac_a;
    logic [PORT_NUM-1:0][HASH_DATA_WIDTH-1:0] dhash_a;
    logic [PORT_NUM-1:0][HASH_DATA_WIDTH-1:0] shash_a;

    assign vlan_a  = i_req_vlan_id;
    assign dmac_a  = i_req_dmac;
    assign smac_a  = i_req_smac;
    assign dhash_a = i_req_dmac_hash;
    assign shash_a = i_req_smac_hash;

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       gidx;
    logic [PORT_NUM-1:0] arb_grant;
    logic [PW-1:0]       arb_idx;
    logic                arb_any;

    rr_arbiter #(.N(PORT_NUM)) u_rr (
        .req   (i_req_vld),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

`ifdef LOOK_UP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state           <= S_IDLE;
            ptr             <= PW'(PORT_NUM - 1);
            gidx            <= '0;
            o_req_ack       <= '0;
            o_vlan_id       <= '0;
            o_dmac_port     <= '0;
            o_dmac_hash_key <= '0;
            o_dmac          <= '0;
            o_dmac_vld      <= 1'b0;
            o_smac_hash_key <= '0;
            o_smac          <= '0;
            o_smac_vld      <= 1'b0;
            o_rslt_port     <= '0;
            o_rslt_vld      <= '0;
            o_busy          <= 1'b0;
`ifdef LOOK_UP_ARB_TIMEOUT_EN
            wait_cnt        <= '0;
            o_timeout       <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle; data outputs hold between issues.
            o_req_ack  <= '0;
            o_dmac_vld <= 1'b0;
            o_smac_vld <= 1'b0;
            o_rslt_vld <= '0;
`ifdef LOOK_UP_ARB_TIMEOUT_EN
            o_timeout  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        gidx            <= arb_idx;
                        o_req_ack       <= arb_grant;
                        o_dmac_port     <= arb_grant;
                        o_vlan_id       <= vlan_a[arb_idx];
                        o_dmac          <= dmac_a[arb_idx];
                        o_dmac_hash_key <= dhash_a[arb_idx];
                        o_smac          <= smac_a[arb_idx];
                        o_smac_hash_key <= shash_a[arb_idx];
                        o_dmac_vld      <= 1'b1;
                        o_smac_vld      <= 1'b1;
                        o_busy          <= 1'b1;
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef LOOK_UP_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_tx_port_vld) begin
                        o_rslt_port <= i_tx_port;
                        o_rslt_vld  <= o_dmac_port;
                        state       <= S_RESP;
                    end
`ifdef LOOK_UP_ARB_TIMEOUT_EN
                    // A result landing on the expiry cycle takes priority above.
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        o_rslt_port <= {1'b0, ~o_dmac_port};
                        o_rslt_vld  <= o_dmac_port;
                        o_timeout   <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    ptr    <= gidx;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_look_up_req_arb.sv
// Directed bench for look_up_req_arb (PORT_NUM=4, HASH=12, TIMEOUT_CYC=16).
module tb_look_up_req_arb;

    localparam int PN = 4;
    localparam int HW = 12;
    localparam int TO = 16;

    logic              clk;
    logic              rst_n;
    logic [PN-1:0]     req_vld;
    logic [PN*12-1:0]  req_vlan;
    logic [PN*48-1:0]  req_dmac;
    logic [PN*HW-1:0]  req_dhash;
    logic [PN*48-1:0]  req_smac;
    logic [PN*HW-1:0]  req_shash;
    logic [PN-1:0]     req_ack;
    logic [11:0]       vlan_id;
    logic [PN-1:0]     dmac_port;
    logic [HW-1:0]     dmac_hash_key;
    logic [47:0]       dmac;
    logic              dmac_vld;
    logic [HW-1:0]     smac_hash_key;
    logic [47:0]       smac;
    logic              smac_vld;
    logic [PN:0]       tx_port;
    logic              tx_port_vld;
    logic [PN:0]       rslt_port;
    logic [PN-1:0]     rslt_vld;
    logic              busy;
    logic              timeout;

    look_up_req_arb #(.PORT_NUM(PN), .HASH_DATA_WIDTH(HW), .TIMEOUT_CYC(TO)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_req_vld(req_vld), .i_req_vlan_id(req_vlan),
        .i_req_dmac(req_dmac), .i_req_dmac_hash(req_dhash),
        .i_req_smac(req_smac), .i_req_smac_hash(req_shash),
        .o_req_ack(req_ack), .o_vlan_id(vlan_id), .o_dmac_port(dmac_port),
        .o_dmac_hash_key(dmac_hash_key), .o_dmac(dmac), .o_dmac_vld(dmac_vld),
        .o_smac_hash_key(smac_hash_key), .o_smac(smac), .o_smac_vld(smac_vld),
        .i_tx_port(tx_port), .i_tx_port_vld(tx_port_vld),
        .o_rslt_port(rslt_port), .o_rslt_vld(rslt_vld),
        .o_busy(busy), .o_timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic [47:0] dmac;
        logic [47:0] smac;
        logic [11:0] vlan;
        logic [11:0] dh;
        logic [11:0] sh;
        int         dly;
        logic [4:0] txp;
        logic [4:0] exp_rp;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for an accept pulse; a miss shows up as a wrong ack value.
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (req_ack == '0 && n < 12);
    endtask

    task automatic drive_fields(input vec_t v);
        req_vlan[v.port*12 +: 12]  = v.vlan;
        req_dmac[v.port*48 +: 48]  = v.dmac;
        req_smac[v.port*48 +: 48]  = v.smac;
        req_dhash[v.port*HW +: HW] = v.dh;
        req_shash[v.port*HW +: HW] = v.sh;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_strobes"}, {req_ack, dmac_vld, smac_vld, rslt_vld, busy, timeout}, 64'h0);
        chk({tag, "_keys"}, {vlan_id, dmac_port, dmac_hash_key, smac_hash_key}, 64'h0);
        chk({tag, "_dmac"}, dmac, 64'h0);
        chk({tag, "_smac"}, smac, 64'h0);
        chk({tag, "_rslt_port"}, rslt_port, 64'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;
    endtask

    // Issue-stage checks plus result delivery for a lone request from IDLE.
    task automatic run_txn(input vec_t v);
        int n;
        drive_fields(v);
        req_vld[v.port] = 1'b1;
        wait_ack(n);
        chk("ack_latency", n, 1);
        chk("req_ack", req_ack, 64'(1) << v.port);
        chk("issue_vld", {dmac_vld, smac_vld}, 2'b11);
        chk("dmac_port", dmac_port, 64'(1) << v.port);
        chk("dmac", dmac, v.dmac);
        chk("smac", smac, v.smac);
        chk("keys", {vlan_id, dmac_hash_key, smac_hash_key}, {v.vlan, v.dh, v.sh});
        req_vld[v.port] = 1'b0;
        tick();
        chk("issue_one_cycle", {req_ack, dmac_vld, smac_vld}, 64'h0);
        chk("dmac_held", dmac, v.dmac);
        repeat (v.dly - 1) tick();
        tx_port = v.txp;
        tx_port_vld = 1'b1;
        tick();
        tx_port_vld = 1'b0;
        tx_port = '0;
        chk("rslt_vld", rslt_vld, 64'(1) << v.port);
        chk("rslt_port", rslt_port, v.exp_rp);
        chk("no_timeout", timeout, 1'b0);
        tick();
        chk("back_idle", {rslt_vld, busy}, 64'h0);
    endtask

    // Complete a transaction whose ack was just sampled.
    task automatic finish_txn(input int p, input logic [4:0] txp);
        tick();
        tx_port = txp;
        tx_port_vld = 1'b1;
        tick();
        tx_port_vld = 1'b0;
        chk("fin_rslt_vld", rslt_vld, 64'(1) << p);
        chk("fin_rslt_port", rslt_port, txp);
    endtask

    vec_t tbl[4];

    initial begin
        int n;
        int seen;
        int ord[5];
        vec_t v;

        tbl[0] = '{2, 48'h0011_2233_4455, 48'hAABB_CCDD_EEFF, 12'h064, 12'h3A5, 12'h5C3, 3,  5'b00010, 5'b00010};
        tbl[1] = '{1, 48'h0000_0000_0001, 48'hFFFF_FFFF_FFFE, 12'hFFF, 12'hFFF, 12'h000, 1,  5'b10000, 5'b10000};
        tbl[2] = '{3, 48'hDEAD_BEEF_CAFE, 48'h1234_5678_9ABC, 12'h001, 12'h800, 12'h7FF, TO, 5'b00101, 5'b00101};
        tbl[3] = '{0, 48'h8000_0000_0000, 48'h0000_0000_8000, 12'hA5A, 12'h00F, 12'hF00, 2,  5'b11110, 5'b11110};
        ord = '{0, 1, 2, 3, 0};

        rst_n = 1'b1;
        req_vld = '0; req_vlan = '0; req_dmac = '0; req_dhash = '0;
        req_smac = '0; req_shash = '0; tx_port = '0; tx_port_vld = 1'b0;
        tick();
        do_reset();

        // Single requests, including local-MAC pass-through and a result on the watchdog expiry cycle.
        for (int i = 0; i < 4; i++) run_txn(tbl[i]);

        // Stray result strobe while idle must not surface.
        tx_port = 5'b00001;
        tx_port_vld = 1'b1;
        tick();
        tx_port_vld = 1'b0;
        chk("stray_no_rslt", {rslt_vld, busy}, 64'h0);
        tick();
        chk("stray_no_rslt2", rslt_vld, 64'h0);
        v = '{1, 48'h0102_0304_0506, 48'h0A0B_0C0D_0E0F, 12'h123, 12'h456, 12'h789, 2, 5'b01000, 5'b01000};
        run_txn(v);

        // Round robin: all four request, port 0 re-requests after its ack.
        do_reset();
        for (int p = 0; p < PN; p++) begin
            v = '{p, 48'(p + 1), 48'(p + 16), 12'(p), 12'(p + 4), 12'(p + 8), 1, 5'b0, 5'b0};
            drive_fields(v);
        end
        req_vld = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(n);
            chk("rr_grant", req_ack, 64'(1) << ord[k]);
            chk("rr_latency", n, (k == 0) ? 1 : 2);
            chk("rr_dmac", dmac, 48'(ord[k] + 1));
            req_vld[ord[k]] = 1'b0;
            if (k == 0) begin
                tick();
                req_vld[0] = 1'b1;
                tx_port = 5'(1 << k);
                tx_port_vld = 1'b1;
                tick();
                tx_port_vld = 1'b0;
                chk("rr_rslt_vld", rslt_vld, 64'(1) << ord[k]);
            end else begin
                finish_txn(ord[k], 5'(1 << k));
            end
        end

        // Reset while port 3 waits for its result.
        req_vld = 4'b1000;
        wait_ack(n);
        chk("rw_grant", req_ack, 4'b1000);
        req_vld = '0;
        tick();
        tick();
        chk("rw_in_wait", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait");
        tx_port = 5'b00001;
        tx_port_vld = 1'b1;
        tick();
        chk("rw_no_rslt", rslt_vld, 64'h0);
        tx_port_vld = 1'b0;
        req_vld = 4'b1001;
        rst_n = 1'b1;
        wait_ack(n);
        chk("rw_first_grant", req_ack, 4'b0001);
        req_vld[0] = 1'b0;
        finish_txn(0, 5'b00100);
        wait_ack(n);
        chk("rw_second_grant", req_ack, 4'b1000);
        req_vld = '0;
        finish_txn(3, 5'b00001);
        tick();

        // Port 1 granted, no result ever arrives.
        req_vld = 4'b0010;
        wait_ack(n);
        chk("to_grant", req_ack, 4'b0010);
        req_vld = '0;
        seen = 0;
`ifdef LOOK_UP_ARB_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            tick();
            if (rslt_vld != '0 || timeout) seen++;
        end
        chk("to_quiet", seen, 0);
        tick();
        chk("to_rslt_vld", rslt_vld, 4'b0010);
        chk("to_rslt_port", rslt_port, 5'b01101);
        chk("to_pulse", timeout, 1'b1);
        tick();
        chk("to_after", {timeout, busy, rslt_vld}, 64'h0);
`else
        for (int i = 0; i < TO + 4; i++) begin
            tick();
            if (rslt_vld != '0 || timeout || !busy) seen++;
        end
        chk("wait_forever", seen, 0);
        finish_txn(1, 5'b00100);
        chk("no_timeout_tie", timeout, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 required less");
        $fatal(1);
    end

endmodule
